// File: rtl/dem_dwa_sched6_if.sv
// Sample-side bundle of the DWA scheduler: request fields in, registered
// element selection and pointer state out.
interface dem_dwa_sched6_if;
    logic       clk_en;
    logic       code_vld;
    logic [2:0] code;
    logic [1:0] mode;
    logic       ptr_clr;
    logic [5:0] sv;
    logic [5:0] st;
    logic [2:0] tcnt;
    logic       sv_vld;
    logic       sat;
    logic [2:0] ptr;

    modport master (
        output clk_en, code_vld, code, mode, ptr_clr,
        input  sv, st, tcnt, sv_vld, sat, ptr
    );
    modport slave (
        input  clk_en, code_vld, code, mode, ptr_clr,
        output sv, st, tcnt, sv_vld, sat, ptr
    );
endinterface

// File: rtl/dem_dwa_sched6.sv
// DWA element scheduler for a 6-element unary DAC: rotates a start pointer so
// element usage averages out, registering select, turn-on vector and count.
module dem_dwa_sched6 #(
    parameter int unsigned PTR_INIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    dem_dwa_sched6_if.slave bus
);
    localparam int         NUM_EL    = 6;
    localparam logic [2:0] PTR_RST   = 3'(PTR_INIT % NUM_EL);
    localparam logic [1:0] MODE_DWA  = 2'b01;
    localparam logic [1:0] MODE_FRZ  = 2'b10;

    logic [NUM_EL-1:0] sv_q, st_q, sv_new, st_new;
    logic [2:0]        tcnt_q, tcnt_new, ptr_q, ptr_nxt, n;
    logic [3:0]        ptr_sum;
    logic              vld_q, sat_q, acc, dwa_sel;

    assign acc     = bus.clk_en & bus.code_vld;
    assign n       = (bus.code == 3'd7) ? 3'd6 : bus.code;
    assign dwa_sel = (bus.mode == MODE_DWA) || (bus.mode == MODE_FRZ);

    // Element i is on when its distance from the pointer (mod 6) is below n.
    for (genvar i = 0; i < NUM_EL; i++) begin : g_el
        logic [3:0] off, rot;
        assign off       = 4'(i) + 4'd6 - {1'b0, ptr_q};
        assign rot       = (off >= 4'd6) ? off - 4'd6 : off;
        assign sv_new[i] = dwa_sel ? (rot < {1'b0, n}) : (4'(i) < {1'b0, n});
    end

    assign st_new = sv_new & ~sv_q;

    always_comb begin
        tcnt_new = 3'd0;
        for (int k = 0; k < NUM_EL; k++)
            tcnt_new = tcnt_new + {2'b00, st_new[k]};
    end

    assign ptr_sum = {1'b0, ptr_q} + {1'b0, n};
    assign ptr_nxt = (ptr_sum >= 4'd6) ? 3'(ptr_sum - 4'd6) : ptr_sum[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sv_q   <= '0;
            st_q   <= '0;
            tcnt_q <= '0;
            vld_q  <= 1'b0;
            sat_q  <= 1'b0;
            ptr_q  <= PTR_RST;
        end else if (bus.clk_en) begin
            if (bus.code_vld) begin
                sv_q   <= sv_new;
                st_q   <= st_new;
                tcnt_q <= tcnt_new;
                vld_q  <= 1'b1;
                sat_q  <= (bus.code == 3'd7);
            end else begin
                st_q   <= '0;
                tcnt_q <= '0;
                vld_q  <= 1'b0;
                sat_q  <= 1'b0;
            end
            // Clear wins over advance; selection above already used the old pointer.
            if (bus.ptr_clr)
                ptr_q <= PTR_RST;
            else if (acc && bus.mode == MODE_DWA)
                ptr_q <= ptr_nxt;
        end
    end

    assign bus.sv     = sv_q;
    assign bus.st     = st_q;
    assign bus.tcnt   = tcnt_q;
    assign bus.sv_vld = vld_q;
    assign bus.sat    = sat_q;
    assign bus.ptr    = ptr_q;
endmodule

// File: tb/tb_dem_dwa_sched6.sv
// Directed bench for dem_dwa_sched6 with hand-computed expected vectors.
module tb_dem_dwa_sched6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    dem_dwa_sched6_if bus ();

    dem_dwa_sched6 #(.PTR_INIT(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] e_sv, input logic [5:0] e_st,
                           input logic [2:0] e_tcnt, input logic e_vld, input logic e_sat,
                           input logic [2:0] e_ptr);
        chk({tag, ".sv"},   {2'b00, bus.sv},   {2'b00, e_sv});
        chk({tag, ".st"},   {2'b00, bus.st},   {2'b00, e_st});
        chk({tag, ".tcnt"}, {5'b0, bus.tcnt},  {5'b0, e_tcnt});
        chk({tag, ".vld"},  {7'b0, bus.sv_vld}, {7'b0, e_vld});
        chk({tag, ".sat"},  {7'b0, bus.sat},   {7'b0, e_sat});
        chk({tag, ".ptr"},  {5'b0, bus.ptr},   {5'b0, e_ptr});
    endtask

    // Apply one set of inputs for a single edge, then sample 1 time unit later.
    task automatic step(input logic en, input logic vld, input logic [2:0] c,
                        input logic [1:0] m, input logic clr);
        bus.clk_en   = en;
        bus.code_vld = vld;
        bus.code     = c;
        bus.mode     = m;
        bus.ptr_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.clk_en = 1'b0; bus.code_vld = 1'b0; bus.code = 3'd0;
        bus.mode = 2'b00; bus.ptr_clr = 1'b0;
        rst = 1'b1;
        step(1'b0, 1'b1, 3'd5, 2'b01, 1'b0);
        chk_all("reset", 6'b000000, 6'b000000, 3'd0, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;

        // DWA 3,3,3
        step(1, 1, 3'd3, 2'b01, 0); chk_all("dwa3a", 6'b000111, 6'b000111, 3'd3, 1, 0, 3'd3);
        step(1, 1, 3'd3, 2'b01, 0); chk_all("dwa3b", 6'b111000, 6'b111000, 3'd3, 1, 0, 3'd0);
        step(1, 1, 3'd3, 2'b01, 0); chk_all("dwa3c", 6'b000111, 6'b000111, 3'd3, 1, 0, 3'd3);
        step(1, 1, 3'd1, 2'b01, 0); chk_all("dwa1",  6'b001000, 6'b001000, 3'd1, 1, 0, 3'd4);

        // wrap from ptr 4, then zero code
        step(1, 1, 3'd4, 2'b01, 0); chk_all("wrap4", 6'b110011, 6'b110011, 3'd4, 1, 0, 3'd2);
        step(1, 1, 3'd0, 2'b01, 0); chk_all("zero",  6'b000000, 6'b000000, 3'd0, 1, 0, 3'd2);
        step(1, 1, 3'd5, 2'b01, 0); chk_all("dwa5",  6'b111101, 6'b111101, 3'd5, 1, 0, 3'd1);

        // saturation then idle
        step(1, 1, 3'd7, 2'b01, 0); chk_all("sat7",  6'b111111, 6'b000010, 3'd1, 1, 1, 3'd1);
        step(1, 0, 3'd7, 2'b01, 0); chk_all("idle",  6'b111111, 6'b000000, 3'd0, 0, 0, 3'd1);

        // thermometer modes 00 and 11
        step(1, 1, 3'd2, 2'b00, 0); chk_all("th2",   6'b000011, 6'b000000, 3'd0, 1, 0, 3'd1);
        step(1, 1, 3'd5, 2'b00, 0); chk_all("th5",   6'b011111, 6'b011100, 3'd3, 1, 0, 3'd1);
        step(1, 1, 3'd1, 2'b11, 0); chk_all("th11",  6'b000001, 6'b000000, 3'd0, 1, 0, 3'd1);

        // move pointer to 5, then frozen DWA
        step(1, 1, 3'd4, 2'b01, 0); chk_all("dwa4",  6'b011110, 6'b011110, 3'd4, 1, 0, 3'd5);
        step(1, 1, 3'd2, 2'b10, 0); chk_all("frz1",  6'b100001, 6'b100001, 3'd2, 1, 0, 3'd5);

        // clk_en low: everything holds, ptr_clr ignored
        step(0, 1, 3'd6, 2'b01, 1); chk_all("gate1", 6'b100001, 6'b100001, 3'd2, 1, 0, 3'd5);
        step(0, 0, 3'd7, 2'b01, 0); chk_all("gate2", 6'b100001, 6'b100001, 3'd2, 1, 0, 3'd5);

        step(1, 1, 3'd2, 2'b10, 0); chk_all("frz2",  6'b100001, 6'b000000, 3'd0, 1, 0, 3'd5);

        // ptr_clr together with a sample
        step(1, 1, 3'd4, 2'b01, 0); chk_all("dwa4b", 6'b100111, 6'b000110, 3'd2, 1, 0, 3'd3);
        step(1, 1, 3'd2, 2'b01, 1); chk_all("clr",   6'b011000, 6'b011000, 3'd2, 1, 0, 3'd0);
        step(1, 1, 3'd3, 2'b01, 0); chk_all("postclr", 6'b000111, 6'b000111, 3'd3, 1, 0, 3'd3);

        // reset mid-stream, then first sample compares against zero
        rst = 1'b1;
        step(1, 1, 3'd5, 2'b01, 0); chk_all("rstmid", 6'b000000, 6'b000000, 3'd0, 0, 0, 3'd0);
        rst = 1'b0;
        step(1, 1, 3'd2, 2'b01, 0); chk_all("postrst", 6'b000011, 6'b000011, 3'd2, 1, 0, 3'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dem_dwa_sched6.md
# dem_dwa_sched6

Data-weighted-averaging (DWA) scheduler for the 6-element unary DAC segment. Each accepted sample carries a thermometer code 0..6, which is the number of unit elements to switch on. The block decides which physical elements carry that code by rotating a start pointer, so element usage is spread evenly. It registers the resulting 6-bit select vector, the per-element off-to-on transition vector and the transition count, and it sits between the digital modulator output and the unit-element drivers.

## Interface
Parameters:
- PTR_INIT, 0: start-pointer value loaded on reset and on `ptr_clr`; legal range 0..5.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  sample-rate enable; when low, all state holds.
- code  in  3  requested element count; values 7 saturate to 6.
- code_vld  in  1  sample valid; qualified by `clk_en`.
- mode  in  2  00 thermometer (fixed order from element 0), 01 DWA, 10 DWA with frozen pointer, 11 treated as 00.
- ptr_clr  in  1  load the pointer with PTR_INIT; qualified by `clk_en`.
- sv  out  6  element select vector; bit i high means element i is on.
- st  out  6  elements that turned on this sample: `sv_new & ~sv_old`.
- tcnt  out  3  popcount of `st`, 0..6.
- sv_vld  out  1  one-cycle pulse, high when `sv`/`st` were updated.
- sat  out  1  high in the cycle after an accepted `code` of 7.
- ptr  out  3  current DWA start pointer, 0..5.

## Operation
- Accept condition: `acc = clk_en & code_vld`.
- Effective count: `n = (code==7) ? 6 : code`.
- Thermometer mode (00/11): `sv_new` bits 0..n-1 high, the rest low; pointer unchanged.
- DWA mode (01): `sv_new` bits ptr, ptr+1, …, ptr+n-1 (mod 6) high.
  - Next pointer = (ptr + n) mod 6.
  - Sum width is 4 bits; subtract 6 when the sum is ≥6.
  - n=0 gives `sv_new` = 0; n=6 gives all ones; in both cases the pointer is unchanged.
- Frozen DWA (10): same selection as 01, but the pointer does not advance.
- On `acc`:
  - `sv <= sv_new`, `st <= sv_new & ~sv`, `tcnt <= popcount(sv_new & ~sv)`.
  - `sv_vld <= 1`, `sat <= (code==7)`.
- When not `acc` and `clk_en`=1: `sv` holds; `st`, `tcnt`, `sv_vld` and `sat` are cleared to 0.
- When `clk_en`=0: every register holds its value, including `sv_vld`, `st`, `tcnt` and `sat`.
- `ptr_clr` with `clk_en`=1:
  - `ptr <= PTR_INIT`. This takes priority over the pointer advance in the same cycle.
  - A sample accepted in that same cycle still uses the old `ptr` for its selection.
- Mode change between samples: the pointer is retained, and the next sample uses the new mode with the current `ptr`.
- PTR_INIT outside 0..5 is illegal; the implementation reduces it mod 6.

## Timing
- Reset (rst=1 at an edge): `sv`=0, `st`=0, `tcnt`=0, `sv_vld`=0, `sat`=0, `ptr`=PTR_INIT. Reset overrides `clk_en`.
- Reset asserted mid-stream: the next cycle shows the reset values. The first sample after reset computes `st` against `sv`=0.
- Latency: 1 cycle from an accepted `code` to `sv`/`st`/`tcnt`/`sv_vld`/`sat`. `ptr` updates on the same edge.
- Throughput: one sample per `clk_en` cycle; there is no backpressure.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset then DWA, codes 3,3,3 on consecutive cycles:
  - `sv` = 000111, 111000, 000111.
  - `ptr` = 3, 0, 3.
  - `st` = 000111, 111000, 000111.
  - `tcnt` = 3, 3, 3.
- DWA wrap with `ptr`=4 and code=4: `sv`=110011, `ptr`→2. Then code=0: `sv`=000000, `st`=0, `ptr` stays 2.
- Saturation, DWA with `ptr`=1 and code=7: `sv`=111111, `sat`=1, `ptr` stays 1. The next idle cycle (`clk_en`=1, `code_vld`=0) gives `sat`=0, `sv_vld`=0, `sv` held.
- Thermometer mode, codes 2 then 5: `sv`=000011 then 011111, `st`=011100, `tcnt`=3, `ptr` unchanged. Frozen DWA with `ptr`=5, code 2, twice: `sv`=100001 both times, second `st`=0.
- `clk_en` gating: with `clk_en`=0, `code_vld`=1 and code=6, all outputs hold their previous values (including `sv_vld` and `st`) and `ptr` does not change.
- `ptr_clr` and sample together, PTR_INIT=0, `ptr`=3, code=2 (DWA): `sv`=011000 and `ptr`→0. Separately, `rst` asserted during a running stream gives all outputs 0 and `ptr`=PTR_INIT on the next cycle.
